// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline (ID->EX->MEM->WB) with load-use stall, bubble and squash logic.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_branch,
    input  logic        id_jump,
    input  logic        id_reg_dst,
    input  logic        id_we_reg,
    input  logic        id_alu_src,
    input  logic        id_we_dm,
    input  logic        id_dm2reg,
    input  logic [1:0]  id_alu_op,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        ex_branch_taken,
    output logic        stall_id,
    output logic        flush_ifid,
    output logic        ex_valid,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_reg_dst,
    output logic        ex_alu_src,
    output logic        ex_we_dm,
    output logic        ex_dm2reg,
    output logic        ex_we_reg,
    output logic [1:0]  ex_alu_op,
    output logic [4:0]  ex_wa,
    output logic        mem_valid,
    output logic        mem_we_dm,
    output logic        mem_dm2reg,
    output logic        mem_we_reg,
    output logic [4:0]  mem_wa,
    output logic        wb_valid,
    output logic        wb_dm2reg,
    output logic        wb_we_reg,
    output logic [4:0]  wb_wa,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       jump;
        logic       reg_dst;
        logic       alu_src;
        logic       we_dm;
        logic       dm2reg;
        logic       we_reg;
        logic [1:0] alu_op;
        logic [4:0] wa;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       we_dm;
        logic       dm2reg;
        logic       we_reg;
        logic [4:0] wa;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       dm2reg;
        logic       we_reg;
        logic [4:0] wa;
    } wb_ctrl_t;

    ex_ctrl_t  r_ex;
    mem_ctrl_t r_mem;
    wb_ctrl_t  r_wb;
    ex_ctrl_t  w_id_bundle;
    ex_ctrl_t  w_ex_next;
    logic [4:0] w_wa;
    logic       w_rt_used;
    logic       w_load_use;

    always_comb begin
        if (id_jump && id_we_reg)
            w_wa = LINK_REG;
        else if (id_reg_dst)
            w_wa = id_rd;
        else
            w_wa = id_rt;
    end

    assign w_rt_used   = id_reg_dst | id_we_dm | id_branch;
    assign w_load_use  = id_valid & r_ex.valid & r_ex.dm2reg & (r_ex.wa != 5'd0)
                       & ((r_ex.wa == id_rs) | (w_rt_used & (r_ex.wa == id_rt)));
    assign w_id_bundle = '{valid: 1'b1, branch: id_branch, jump: id_jump,
                           reg_dst: id_reg_dst, alu_src: id_alu_src, we_dm: id_we_dm,
                           dm2reg: id_dm2reg, we_reg: id_we_reg, alu_op: id_alu_op, wa: w_wa};

    // A taken branch wins over load-use: the stalled instruction is wrong-path anyway.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_ex_next  = '0;
        stall_id   = 1'b0;
        flush_ifid = 1'b0;
        if (ex_branch_taken) begin
            flush_ifid = 1'b1;
        end else if (w_load_use) begin
            stall_id = 1'b1;
        end else begin
            flush_ifid = id_valid & id_jump;
            if (id_valid)
                w_ex_next = w_id_bundle;
        end
    end

    // NOTE: stage registers use non-blocking assignment so all stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_next;
            r_mem <= '{valid: r_ex.valid, we_dm: r_ex.we_dm, dm2reg: r_ex.dm2reg,
                       we_reg: r_ex.we_reg, wa: r_ex.wa};
            r_wb  <= '{valid: r_mem.valid, dm2reg: r_mem.dm2reg,
                       we_reg: r_mem.we_reg, wa: r_mem.wa};
        end
    end

    assign ex_valid   = r_ex.valid;
    assign ex_branch  = r_ex.branch;
    assign ex_jump    = r_ex.jump;
    assign ex_reg_dst = r_ex.reg_dst;
    assign ex_alu_src = r_ex.alu_src;
    assign ex_we_dm   = r_ex.we_dm;
    assign ex_dm2reg  = r_ex.dm2reg;
    assign ex_we_reg  = r_ex.we_reg;
    assign ex_alu_op  = r_ex.alu_op;
    assign ex_wa      = r_ex.wa;
    assign mem_valid  = r_mem.valid;
    assign mem_we_dm  = r_mem.we_dm;
    assign mem_dm2reg = r_mem.dm2reg;
    assign mem_we_reg = r_mem.we_reg;
    assign mem_wa     = r_mem.wa;
    assign wb_valid   = r_wb.valid;
    assign wb_dm2reg  = r_wb.dm2reg;
    assign wb_we_reg  = r_wb.we_reg;
    assign wb_wa      = r_wb.wa;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_id && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_ifid && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe: expected EX bundles are queued at drive time and
// checked when they emerge, with MEM/WB expectations shifted along behind them.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       jump;
        logic       reg_dst;
        logic       alu_src;
        logic       we_dm;
        logic       dm2reg;
        logic       we_reg;
        logic [1:0] alu_op;
        logic [4:0] wa;
    } bundle_t;

    typedef struct packed {
        logic       valid;
        logic       we_dm;
        logic       dm2reg;
        logic       we_reg;
        logic [4:0] wa;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       dm2reg;
        logic       we_reg;
        logic [4:0] wa;
    } wb_t;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       jump;
        logic       reg_dst;
        logic       we_reg;
        logic       alu_src;
        logic       we_dm;
        logic       dm2reg;
        logic [1:0] alu_op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } id_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_branch, id_jump, id_reg_dst, id_we_reg;
    logic        id_alu_src, id_we_dm, id_dm2reg;
    logic [1:0]  id_alu_op;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_branch_taken;
    logic        stall_id, flush_ifid;
    logic        ex_valid, ex_branch, ex_jump, ex_reg_dst, ex_alu_src;
    logic        ex_we_dm, ex_dm2reg, ex_we_reg;
    logic [1:0]  ex_alu_op;
    logic [4:0]  ex_wa;
    logic        mem_valid, mem_we_dm, mem_dm2reg, mem_we_reg;
    logic [4:0]  mem_wa;
    logic        wb_valid, wb_dm2reg, wb_we_reg;
    logic [4:0]  wb_wa;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bundle_t     ex_q[$];
    bundle_t     m_ex;
    mem_t        m_mem;
    wb_t         m_wb;
    logic [31:0] exp_sc;
    logic [31:0] exp_fc;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_branch(id_branch), .id_jump(id_jump),
        .id_reg_dst(id_reg_dst), .id_we_reg(id_we_reg), .id_alu_src(id_alu_src),
        .id_we_dm(id_we_dm), .id_dm2reg(id_dm2reg), .id_alu_op(id_alu_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken),
        .stall_id(stall_id), .flush_ifid(flush_ifid),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_we_dm(ex_we_dm),
        .ex_dm2reg(ex_dm2reg), .ex_we_reg(ex_we_reg), .ex_alu_op(ex_alu_op), .ex_wa(ex_wa),
        .mem_valid(mem_valid), .mem_we_dm(mem_we_dm), .mem_dm2reg(mem_dm2reg),
        .mem_we_reg(mem_we_reg), .mem_wa(mem_wa),
        .wb_valid(wb_valid), .wb_dm2reg(wb_dm2reg), .wb_we_reg(wb_we_reg), .wb_wa(wb_wa),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction builder: valid is always 1.
    function automatic id_t ins(input logic br, input logic jmp, input logic rdst,
                                input logic wreg, input logic asrc, input logic wdm,
                                input logic d2r, input logic [1:0] op,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return '{valid: 1'b1, branch: br, jump: jmp, reg_dst: rdst, we_reg: wreg,
                 alu_src: asrc, we_dm: wdm, dm2reg: d2r, alu_op: op, rs: rs, rt: rt, rd: rd};
    endfunction

    function automatic bundle_t bx(input logic v, input logic br, input logic jmp,
                                   input logic rdst, input logic asrc, input logic wdm,
                                   input logic d2r, input logic wreg, input logic [1:0] op,
                                   input logic [4:0] wa);
        return '{valid: v, branch: br, jump: jmp, reg_dst: rdst, alu_src: asrc,
                 we_dm: wdm, dm2reg: d2r, we_reg: wreg, alu_op: op, wa: wa};
    endfunction

    function automatic id_t add_i(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return ins(0, 0, 1, 1, 0, 0, 0, 2'b10, rs, rt, rd);
    endfunction

    function automatic id_t lw_i(input logic [4:0] rt);
        return ins(0, 0, 0, 1, 1, 0, 1, 2'b00, 5'd0, rt, 5'd0);
    endfunction

    function automatic bundle_t add_b(input logic [4:0] rd);
        return bx(1, 0, 0, 1, 0, 0, 0, 1, 2'b10, rd);
    endfunction

    function automatic bundle_t lw_b(input logic [4:0] rt);
        return bx(1, 0, 0, 0, 1, 0, 1, 1, 2'b00, rt);
    endfunction

    task automatic drive(input id_t id, input logic bt);
        id_valid        = id.valid;
        id_branch       = id.branch;
        id_jump         = id.jump;
        id_reg_dst      = id.reg_dst;
        id_we_reg       = id.we_reg;
        id_alu_src      = id.alu_src;
        id_we_dm        = id.we_dm;
        id_dm2reg       = id.dm2reg;
        id_alu_op       = id.alu_op;
        id_rs           = id.rs;
        id_rt           = id.rt;
        id_rd           = id.rd;
        ex_branch_taken = bt;
    endtask

    task automatic compare_stages();
        bundle_t obs_ex;
        mem_t    obs_mem;
        wb_t     obs_wb;
        obs_ex  = {ex_valid, ex_branch, ex_jump, ex_reg_dst, ex_alu_src, ex_we_dm,
                   ex_dm2reg, ex_we_reg, ex_alu_op, ex_wa};
        obs_mem = {mem_valid, mem_we_dm, mem_dm2reg, mem_we_reg, mem_wa};
        obs_wb  = {wb_valid, wb_dm2reg, wb_we_reg, wb_wa};
        chk("ex_bundle", 32'(obs_ex), 32'(m_ex));
        chk("mem_bundle", 32'(obs_mem), 32'(m_mem));
        chk("wb_bundle", 32'(obs_wb), 32'(m_wb));
        chk("stall_cnt", stall_cnt, exp_sc);
        chk("flush_cnt", flush_cnt, exp_fc);
    endtask

    task automatic model_reset();
        ex_q.delete();
        m_ex   = '0;
        m_mem  = '0;
        m_wb   = '0;
        exp_sc = '0;
        exp_fc = '0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input id_t id, input logic bt, input logic e_stall,
                        input logic e_flush, input bundle_t e_ex);
        drive(id, bt);
        #3;
        chk("stall_id", 32'(stall_id), 32'(e_stall));
        chk("flush_ifid", 32'(flush_ifid), 32'(e_flush));
        ex_q.push_back(e_ex);
`ifdef CTRL_PIPE_PERF_EN
        if (e_stall) exp_sc = exp_sc + 32'd1;
        if (e_flush) exp_fc = exp_fc + 32'd1;
`endif
        @(posedge clk);
        #1;
        m_wb  = '{valid: m_mem.valid, dm2reg: m_mem.dm2reg, we_reg: m_mem.we_reg, wa: m_mem.wa};
        m_mem = '{valid: m_ex.valid, we_dm: m_ex.we_dm, dm2reg: m_ex.dm2reg,
                  we_reg: m_ex.we_reg, wa: m_ex.wa};
        if (ex_q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
            m_ex = '0;
        end else begin
            m_ex = ex_q.pop_front();
        end
        compare_stages();
    endtask

    initial begin
        id_t     nop;
        bundle_t bub;
        nop = '0;
        bub = '0;

        rst_n = 1'b0;
        drive(nop, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_stages();
        chk("rst_stall_id", 32'(stall_id), 32'd0);
        chk("rst_flush_ifid", 32'(flush_ifid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type add flows to WB after three edges.
        step(add_i(5'd1, 5'd2, 5'd5), 0, 0, 0, add_b(5'd5));
        step(nop, 0, 0, 0, bub);
        step(nop, 0, 0, 0, bub);

        // LW $8 then consumer of $8 via rs: one-cycle stall, then it advances.
        step(lw_i(5'd8), 0, 0, 0, lw_b(5'd8));
        step(add_i(5'd8, 5'd3, 5'd9), 0, 1, 0, bub);
        step(add_i(5'd8, 5'd3, 5'd9), 0, 0, 0, add_b(5'd9));

        // Load to $0 never stalls its consumer.
        step(lw_i(5'd0), 0, 0, 0, lw_b(5'd0));
        step(add_i(5'd0, 5'd0, 5'd4), 0, 0, 0, add_b(5'd4));

        // rt match only counts when rt is a source.
        step(lw_i(5'd7), 0, 0, 0, lw_b(5'd7));
        step(ins(0, 0, 0, 1, 1, 0, 0, 2'b00, 5'd2, 5'd7, 5'd0), 0, 0, 0,
             bx(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 5'd7));
        step(lw_i(5'd7), 0, 0, 0, lw_b(5'd7));
        step(ins(0, 0, 0, 0, 1, 1, 0, 2'b00, 5'd1, 5'd7, 5'd0), 0, 1, 0, bub);
        step(ins(0, 0, 0, 0, 1, 1, 0, 2'b00, 5'd1, 5'd7, 5'd0), 0, 0, 0,
             bx(1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 5'd7));

        // JAL flushes IF/ID and links to $31.
        step(ins(0, 1, 0, 1, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0), 0, 0, 1,
             bx(1, 0, 1, 0, 0, 0, 0, 1, 2'b00, 5'd31));

        // Untaken BEQ passes through with its branch bit.
        step(ins(1, 0, 0, 0, 0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0), 0, 0, 0,
             bx(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 5'd2));

        // Taken branch overrides a simultaneous load-use hazard.
        step(lw_i(5'd8), 0, 0, 0, lw_b(5'd8));
        step(add_i(5'd8, 5'd3, 5'd9), 1, 0, 1, bub);

        // Jump under a load-use stall flushes only when it advances.
        step(lw_i(5'd8), 0, 0, 0, lw_b(5'd8));
        step(ins(0, 1, 0, 0, 0, 0, 0, 2'b00, 5'd8, 5'd0, 5'd0), 0, 1, 0, bub);
        step(ins(0, 1, 0, 0, 0, 0, 0, 2'b00, 5'd8, 5'd0, 5'd0), 0, 0, 1,
             bx(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 5'd0));

        // Fill EX/MEM/WB, then reset mid-cycle: everything drops at once.
        step(add_i(5'd1, 5'd2, 5'd10), 0, 0, 0, add_b(5'd10));
        step(add_i(5'd1, 5'd2, 5'd11), 0, 0, 0, add_b(5'd11));
        step(add_i(5'd1, 5'd2, 5'd12), 0, 0, 0, add_b(5'd12));
        chk("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
        drive(nop, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_stages();
        chk("mid_rst_stall_id", 32'(stall_id), 32'd0);
        chk("mid_rst_flush_ifid", 32'(flush_ifid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_stages();

        // Normal flow resumes after release.
        step(add_i(5'd3, 5'd4, 5'd13), 0, 0, 0, add_b(5'd13));
        step(nop, 0, 0, 0, bub);
        step(nop, 0, 0, 0, bub);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundle from the main decoder through the EX, MEM and WB pipeline registers of the 5-stage MIPS core. Also owns the pipeline's control hazards: load-use stall detection, bubble insertion, and squashing of wrong-path instructions on taken branches and jumps. It sits directly downstream of the main decoder in ID and feeds every later-stage control input.

## Interface
Parameters:
- none; register-address width fixed at 5, JAL link register fixed at 31.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction; 0 means ignore all id_* fields.
- id_branch, id_jump, id_reg_dst, id_we_reg, id_alu_src, id_we_dm, id_dm2reg  in  1 each  decoder outputs.
- id_alu_op  in  2  decoder ALU-op class.
- id_rs, id_rt, id_rd  in  5 each  instruction register fields.
- ex_branch_taken  in  1  EX branch condition true; the EX-stage instruction is a branch.
- stall_id  out  1  hold PC and the IF/ID register this cycle.
- flush_ifid  out  1  load a bubble into IF/ID at the next edge.
- ex_valid, ex_branch, ex_jump, ex_reg_dst, ex_alu_src, ex_we_dm, ex_dm2reg, ex_we_reg  out  1 each  EX-stage control.
- ex_alu_op  out  2  EX-stage ALU-op class.
- ex_wa  out  5  EX-stage destination register.
- mem_valid, mem_we_dm, mem_dm2reg, mem_we_reg  out  1 each; mem_wa  out  5  MEM-stage control.
- wb_valid, wb_dm2reg, wb_we_reg  out  1 each; wb_wa  out  5  WB-stage control.
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
- Destination address: id_jump & id_we_reg gives 31 (JAL). Otherwise id_reg_dst gives id_rd, else id_rt. The result is registered into ex_wa.
- rt_used = id_reg_dst | id_we_dm | id_branch.
- Load-use hazard when all of the following hold: id_valid, ex_valid, ex_dm2reg, ex_wa != 0, and (ex_wa == id_rs or (rt_used and ex_wa == id_rt)).
- Bubble means every valid, enable and control bit is 0, alu_op is 0, and wa is 0.
- Per edge, with priority top-down:
  - ex_branch_taken: EX loads a bubble (squashes the ID instruction). flush_ifid = 1. stall_id = 0.
  - Load-use hazard: EX loads a bubble. stall_id = 1. flush_ifid = 0.
  - Otherwise: EX loads the ID bundle when id_valid, else a bubble. flush_ifid = id_valid & id_jump.
- MEM always loads from EX, and WB always loads from MEM; no stall reaches them.
- A taken branch overrides a simultaneous load-use hazard. The stalled instruction is wrong-path, so stall_id stays 0.
- A jump in ID coincident with a load-use stall does not flush. The flush fires on the cycle the jump advances.

## Timing
- Async reset clears every stage register to a bubble. All out ports read 0 during and after reset until the first edge with id_valid = 1. Counters reset to 0.
- Stage outputs are registered: ID to ex_* is 1 cycle, ex_* to mem_* is 1 cycle, mem_* to wb_* is 1 cycle.
- stall_id and flush_ifid are combinational from the current id_* inputs, the ex_* registers and ex_branch_taken. There is no register between input and output.
- A load-use stall lasts exactly 1 cycle: once the load moves to MEM, ex_dm2reg is 0.
- Reset asserted mid-operation discards all in-flight instructions. There is no partial retirement.

## Configuration
- CTRL_PIPE_PERF_EN defined:
  - stall_cnt increments on each edge where stall_id = 1.
  - flush_cnt increments on each edge where flush_ifid = 1.
  - Both counters saturate at 32'hFFFF_FFFF.
- CTRL_PIPE_PERF_EN undefined: no counter flops; both ports are tied to 0. The port list is identical in both builds.

## Test plan
- Reset then R-type add (reg_dst=1, we_reg=1, alu_op=2'b10, rd=5) -> ex_we_reg=1, ex_wa=5 after 1 edge; wb_we_reg=1, wb_wa=5 after 3 edges; all outputs 0 before.
- LW to $8 followed by ADD using rs=$8 -> stall_id=1 for exactly 1 cycle; EX bubble; ADD reaches ex_valid 1 cycle later; stall_cnt=1 when perf enabled.
- LW to $0 followed by a consumer of $0 -> stall_id stays 0.
- JAL (jump=1, we_reg=1) -> flush_ifid=1 that cycle; ex_wa=31, ex_we_reg=1 next edge.
- BEQ with ex_branch_taken=1 while ID holds a load-use consumer -> flush_ifid=1, stall_id=0, EX bubble, flush_cnt=1, stall_cnt unchanged.
- rst_n pulsed low mid-stream with valid instructions in EX, MEM and WB -> all *_valid and enables read 0 immediately; normal flow resumes after release.
